pipe_temp_monitor: RTL and testbench

- Multi-channel successor to the single-ADC pipe temperature controller.
- Scans NUM_CH ADC channels on each sample tick and applies per-channel alarm and global shutdown thresholds with hysteresis.
- Streams one framed telemetry packet per scan to the UART transmitter over a valid/ready byte handshake.
- Sits between the ADC inputs, the digital-clock tick source and the uArtTx instance at top level.

---
 rtl/pipe_temp_pkg.sv | 25 ++
 rtl/pipe_temp_monitor_thresh_hyst.sv | 37 +++
 rtl/pipe_temp_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_temp_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_temp_pkg.sv
// Shared types and constants for the multi-channel pipe temperature monitor.
// Holds the frame FSM states, STAT byte layout and the sample byte-count helper.
package pipe_temp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    EVAL,
    SEND_SYNC,
    SEND_STAT,
    SEND_TEMP,
    SEND_SUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int STAT_SHUT_BIT = 7;
  localparam int STAT_OVR_BIT  = 6;
  localparam int STAT_ALARM_W  = 6;

  function automatic int calc_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pipe_temp_monitor_thresh_hyst.sv
// Per-channel alarm flag with set threshold and hysteretic clear threshold.
// The flag only moves on the evaluation strobe; between the two thresholds it holds.
module thresh_hyst
  import pipe_temp_pkg::*;
#(
  parameter int             W      = 8,
  parameter logic [W-1:0]   SET_TH = '0,
  parameter logic [W-1:0]   HYST   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] sample,
  output logic         flag
);

  localparam logic [W-1:0] CLR_TH = SET_TH - HYST;

  logic set_c;
  logic clr_c;

  assign set_c = (sample >= SET_TH);
  assign clr_c = (sample < CLR_TH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag <= 1'b0;
    end else if (en) begin
      if (set_c) begin
        flag <= 1'b1;
      end else if (clr_c) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_temp_monitor.sv
// Scans NUM_CH ADC channels per sample tick, applies alarm/shutdown thresholds
// with hysteresis and streams one framed telemetry packet per scan to the UART.
//
// state     | meaning
// IDLE      | waiting for sample_tick, busy low
// CAPTURE   | latch all channel samples together
// EVAL      | update alarm flags and shutdown set condition
// SEND_SYNC | frame start byte on tx_data
// SEND_STAT | {shutdown, overrun, alarm[5:0]}
// SEND_TEMP | sample bytes, channel 0 first, MSB byte first
// SEND_SUM  | mod-256 sum of STAT and TEMP bytes, then back to IDLE
module pipe_temp_monitor
  import pipe_temp_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                TEMP_W    = 8,
  parameter logic [TEMP_W-1:0] ALARM_TH  = 80,
  parameter logic [TEMP_W-1:0] SHUT_TH   = 100,
  parameter logic [TEMP_W-1:0] HYST      = 5,
  parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*TEMP_W-1:0] adc_data,
  input  logic                     sample_tick,
  input  logic                     shutdown_clr,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     shutdown,
  output logic                     overrun,
  output logic                     busy
);

  localparam int BYTES = calc_bytes(TEMP_W);
  localparam int NB    = NUM_CH * BYTES;
  localparam int IDX_W = $clog2(NB + 1);
  localparam int SA_W  = (NUM_CH < STAT_ALARM_W) ? NUM_CH : STAT_ALARM_W;

  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NB - 1);
  localparam logic [TEMP_W-1:0] SHUT_CLR_TH = SHUT_TH - HYST;

  state_t             state;
  logic [TEMP_W-1:0]  samp [NUM_CH];
  logic [7:0]         sum;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               eval_en;
  logic               accept;
  logic               any_shut;
  logic               all_low;
  logic [NB*8-1:0]    temp_flat;
  logic [BYTES*8-1:0] ext;
  logic [7:0]         temp_next;
  logic [STAT_ALARM_W-1:0] stat_alarm;
  logic [7:0]         stat_byte;

  assign eval_en = (state == EVAL);
  assign accept  = tx_valid && tx_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    thresh_hyst #(
      .W      (TEMP_W),
      .SET_TH (ALARM_TH),
      .HYST   (HYST)
    ) u_thresh (
      .clk    (clk),
      .reset  (reset),
      .en     (eval_en),
      .sample (samp[i]),
      .flag   (alarm[i])
    );
  end

  // Sample registers only change at CAPTURE, so these always reflect the latest scan.
  always_comb begin
    any_shut = 1'b0;
    all_low  = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (samp[i] >= SHUT_TH) any_shut = 1'b1;
      if (samp[i] >= SHUT_CLR_TH) all_low = 1'b0;
    end
  end

  always_comb begin
    temp_flat = '0;
    ext       = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ext               = '0;
      ext[TEMP_W-1:0]   = samp[ch];
      for (int j = 0; j < BYTES; j++) begin
        temp_flat[(ch*BYTES + j)*8 +: 8] = ext[(BYTES-1-j)*8 +: 8];
      end
    end
  end

  assign sel_idx = (state == SEND_TEMP) ? idx + 1'b1 : '0;

  always_comb begin
    temp_next = '0;
    for (int k = 0; k < NB; k++) begin
      if (sel_idx == IDX_W'(k)) temp_next = temp_flat[k*8 +: 8];
    end
  end

  always_comb begin
    stat_alarm           = '0;
    stat_alarm[SA_W-1:0] = alarm[SA_W-1:0];
  end

  assign stat_byte = {shutdown, overrun, stat_alarm};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      sum      <= '0;
      idx      <= '0;
      shutdown <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) samp[i] <= '0;
    end else begin
      // A fresh drop outranks clearing; only a transmitted overrun bit is cleared.
      if (sample_tick && busy) begin
        overrun <= 1'b1;
      end else if (state == SEND_STAT && accept && tx_data[STAT_OVR_BIT]) begin
        overrun <= 1'b0;
      end

      if (state == EVAL && any_shut) begin
        shutdown <= 1'b1;
      end else if (shutdown_clr && all_low) begin
        shutdown <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= CAPTURE;
            busy  <= 1'b1;
            sum   <= '0;
            idx   <= '0;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < NUM_CH; i++) samp[i] <= adc_data[i*TEMP_W +: TEMP_W];
          state <= EVAL;
        end
        EVAL: begin
          state    <= SEND_SYNC;
          tx_data  <= SYNC_BYTE;
          tx_valid <= 1'b1;
        end
        SEND_SYNC: begin
          if (accept) begin
            state   <= SEND_STAT;
            tx_data <= stat_byte;
          end
        end
        SEND_STAT: begin
          if (accept) begin
            state   <= SEND_TEMP;
            sum     <= sum + tx_data;
            idx     <= '0;
            tx_data <= temp_next;
          end
        end
        SEND_TEMP: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state   <= SEND_SUM;
              tx_data <= sum + tx_data;
            end else begin
              sum     <= sum + tx_data;
              idx     <= idx + 1'b1;
              tx_data <= temp_next;
            end
          end
        end
        SEND_SUM: begin
          if (accept) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_temp_monitor.sv
// Directed bench: a 4x8-bit monitor driven from a vector table plus stall,
// overrun and async-reset sequences, and a 2x12-bit instance for multi-byte samples.
module tb_pipe_temp_monitor;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] adc_a;
  logic [23:0] adc_b;
  logic        tick_a, tick_b, clr_a, clr_b, ready;
  logic [7:0]  txd_a, txd_b;
  logic        txv_a, txv_b;
  logic [3:0]  alarm_a;
  logic [1:0]  alarm_b;
  logic        shut_a, shut_b, ovr_a, ovr_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_temp_monitor u_dut_a (
    .clk(clk), .reset(rst_a), .adc_data(adc_a), .sample_tick(tick_a),
    .shutdown_clr(clr_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(ready),
    .alarm(alarm_a), .shutdown(shut_a), .overrun(ovr_a), .busy(busy_a)
  );

  pipe_temp_monitor #(
    .NUM_CH(2), .TEMP_W(12), .ALARM_TH(12'hC00), .SHUT_TH(12'hE00), .HYST(12'h010)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .adc_data(adc_b), .sample_tick(tick_b),
    .shutdown_clr(clr_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(ready),
    .alarm(alarm_b), .shutdown(shut_b), .overrun(ovr_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] adc;
    logic        clr;
    logic [55:0] frame;
    logic [3:0]  alarm;
    logic        shut;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts a scan at the current negedge and collects up to 7 accepted bytes.
  task automatic run_frame(input bit sel, input bit stall, input int tick_at,
                           output logic [55:0] got, output int nb, output int lat);
    logic       v;
    logic [7:0] d, held;
    bit         was_stalled;
    int         cyc;
    got = '0; nb = 0; lat = -1; was_stalled = 0; held = '0;
    if (sel) tick_b = 1'b1; else tick_a = 1'b1;
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    tick_a = 1'b0; tick_b = 1'b0;
    cyc = 1;
    while (nb < 7 && cyc < 200) begin
      v = sel ? txv_b : txv_a;
      d = sel ? txd_b : txd_a;
      if (stall) ready = (cyc % 3 == 0);
      if (v && lat < 0) lat = cyc;
      if (was_stalled) chk("stall_hold", d, held);
      if (v && ready) begin
        if (nb == tick_at) begin
          if (sel) tick_b = 1'b1; else tick_a = 1'b1;
        end
        got = {got[47:0], d};
        nb++;
        was_stalled = 0;
      end else if (v) begin
        was_stalled = 1;
        held = d;
      end
      @(posedge clk); @(negedge clk);
      tick_a = 1'b0; tick_b = 1'b0;
      cyc++;
    end
    ready = 1'b1;
  endtask

  localparam logic [55:0] FRAME_BASE = 56'hA5_00_28_1E_14_0A_64;
  localparam logic [55:0] FRAME_OVR  = 56'hA5_40_28_1E_14_0A_A4;

  initial begin
    logic [55:0] got;
    int nb, lat;

    vecs[0] = '{32'h0A_14_1E_28, 1'b0, 56'hA5_00_28_1E_14_0A_64, 4'b0000, 1'b0};
    vecs[1] = '{32'h0A_14_4F_28, 1'b0, 56'hA5_00_28_4F_14_0A_95, 4'b0000, 1'b0};
    vecs[2] = '{32'h0A_14_50_28, 1'b0, 56'hA5_02_28_50_14_0A_98, 4'b0010, 1'b0};
    vecs[3] = '{32'h0A_14_4D_28, 1'b0, 56'hA5_02_28_4D_14_0A_95, 4'b0010, 1'b0};
    vecs[4] = '{32'h0A_14_4B_28, 1'b0, 56'hA5_02_28_4B_14_0A_93, 4'b0010, 1'b0};
    vecs[5] = '{32'h0A_14_4A_28, 1'b0, 56'hA5_00_28_4A_14_0A_90, 4'b0000, 1'b0};
    vecs[6] = '{32'h0A_64_4A_28, 1'b0, 56'hA5_84_28_4A_64_0A_64, 4'b0100, 1'b1};
    vecs[7] = '{32'h0A_60_4A_28, 1'b1, 56'hA5_84_28_4A_60_0A_60, 4'b0100, 1'b1};
    vecs[8] = '{32'h0A_5E_4A_28, 1'b1, 56'hA5_84_28_4A_5E_0A_5E, 4'b0100, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0;
    tick_a = 1'b0; tick_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0; ready = 1'b1;
    adc_a = vecs[0].adc; adc_b = {12'h123, 12'hABC};
    repeat (3) @(negedge clk);
    chk("rst_tx_data", txd_a, 8'h00);
    chk("rst_tx_valid", txv_a, 1'b0);
    chk("rst_alarm", alarm_a, 4'h0);
    chk("rst_shutdown", shut_a, 1'b0);
    chk("rst_overrun", ovr_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_b_tx_valid", txv_b, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      adc_a = vecs[i].adc;
      run_frame(1'b0, 1'b0, -1, got, nb, lat);
      chk($sformatf("v%0d_nbytes", i), nb, 7);
      chk($sformatf("v%0d_frame", i), got, vecs[i].frame);
      if (i == 0) chk("first_valid_latency", lat, 3);
      if (vecs[i].clr) begin
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("v%0d_alarm", i), alarm_a, vecs[i].alarm);
      chk($sformatf("v%0d_shutdown", i), shut_a, vecs[i].shut);
      chk($sformatf("v%0d_busy_after", i), busy_a, 1'b0);
    end

    adc_a = vecs[0].adc;
    run_frame(1'b0, 1'b1, -1, got, nb, lat);
    chk("stall_nbytes", nb, 7);
    chk("stall_frame", got, FRAME_BASE);

    run_frame(1'b0, 1'b0, 3, got, nb, lat);
    chk("ovr1_frame", got, FRAME_BASE);
    chk("ovr1_overrun", ovr_a, 1'b1);
    chk("ovr1_busy", busy_a, 1'b0);
    run_frame(1'b0, 1'b0, -1, got, nb, lat);
    chk("ovr2_frame", got, FRAME_OVR);
    chk("ovr2_overrun_cleared", ovr_a, 1'b0);
    run_frame(1'b0, 1'b0, 6, got, nb, lat);
    chk("ovr3_frame", got, FRAME_BASE);
    chk("ovr3_tick_at_sum_overrun", ovr_a, 1'b1);
    chk("ovr3_tick_at_sum_dropped", busy_a, 1'b0);
    run_frame(1'b0, 1'b0, -1, got, nb, lat);
    chk("ovr4_frame", got, FRAME_OVR);
    chk("ovr4_overrun_cleared", ovr_a, 1'b0);

    run_frame(1'b1, 1'b0, -1, got, nb, lat);
    chk("w12_nbytes", nb, 7);
    chk("w12_frame", got, 56'hA5_00_0A_BC_01_23_EA);
    chk("w12_alarm", alarm_b, 2'b00);
    chk("w12_shutdown", shut_b, 1'b0);

    tick_b = 1'b1;
    @(negedge clk);
    tick_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_pre_valid", txv_b, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    chk("midreset_tx_valid", txv_b, 1'b0);
    chk("midreset_busy", busy_b, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_frame(1'b1, 1'b0, -1, got, nb, lat);
    chk("postreset_frame", got, 56'hA5_00_0A_BC_01_23_EA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

endmodule
